// File: rtl/matrix_result_writer.sv
// rtl/matrix_result_writer.sv - collects per-row matrix-vector results into a buffer
//
// Ports:
//   CLOCK_50  system clock (rising edge)
//   KEY0      asynchronous active-high reset
//   start     pulse: clear the buffer and begin a new collection
//   in_valid / in_ready / in_row / in_data   row-result input stream
//   rd_addr / rd_data    registered readback port (1-cycle latency)
//   count     distinct rows accepted
//   checksum  wrapping sum of accepted row data
//   cycles    saturating count of cycles spent in CLEAR+COLLECT
//   err       sticky duplicate / out-of-range row flag
//   done      every row collected
module matrix_result_writer #(
  parameter int N_ROWS = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_row,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum,
  output logic [31:0]       cycles,
  output logic              err,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DONE} state_t;

  localparam logic [ADDR_W:0]   N_ROWS_C = (ADDR_W+1)'(N_ROWS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_ROWS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [N_ROWS-1:0]   valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic [31:0]         cycles_q, cycles_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // Result storage has no reset; CLEAR zeroes it after every start.
  logic [DATA_W-1:0]   buffer_q [N_ROWS];
  logic                buf_we;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_wdata;

  logic accept, in_range, dup, good, bad, clr_we;

  assign accept   = in_valid & in_ready;
  assign in_range = ({1'b0, in_row} < N_ROWS_C);
  assign dup      = in_range & valid_q[in_row];
  assign good     = accept & in_range & ~dup;
  assign bad      = accept & ~(in_range & ~dup);

  // State register
  always_ff @(posedge CLOCK_50 or posedge KEY0) begin
    if (KEY0) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start overrides every state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_CLEAR:   if (ptr_q == LAST_PTR) state_d = S_COLLECT;
        S_COLLECT: if (good && (count_q == N_ROWS_C - 1'b1)) state_d = S_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == S_COLLECT) & ~start;
    done     = (state_q == S_DONE);
    clr_we   = (state_q == S_CLEAR);
  end

  // Datapath next values and buffer write port
  always_comb begin
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    buf_we     = 1'b0;
    buf_addr   = ptr_q;
    buf_wdata  = '0;
    if (start) begin
      ptr_d      = '0;
      valid_d    = '0;
      count_d    = '0;
      checksum_d = '0;
      cycles_d   = '0;
      err_d      = 1'b0;
    end else begin
      if (clr_we) begin
        buf_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
      end
      if (good) begin
        buf_we           = 1'b1;
        buf_addr         = in_row;
        buf_wdata        = in_data;
        valid_d[in_row]  = 1'b1;
        count_d          = count_q + 1'b1;
        checksum_d       = checksum_q + in_data;
      end
      if (bad) err_d = 1'b1;
      if (((state_q == S_CLEAR) || (state_q == S_COLLECT)) && (cycles_q != '1))
        cycles_d = cycles_q + 1'b1;
    end
    rd_data_d = ({1'b0, rd_addr} < N_ROWS_C) ? buffer_q[rd_addr] : '0;
  end

  always_ff @(posedge CLOCK_50 or posedge KEY0) begin
    if (KEY0) begin
      ptr_q      <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (buf_we) buffer_q[buf_addr] <= buf_wdata;
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign checksum = checksum_q;
  assign cycles   = cycles_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matrix_result_writer.sv
// tb/tb_matrix_result_writer.sv - directed scoreboard bench for matrix_result_writer
module tb_matrix_result_writer;

  localparam int N_ROWS = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              CLOCK_50 = 1'b0;
  logic              KEY0;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_row;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] checksum;
  logic [31:0]       cycles;
  logic              err;
  logic              done;

  matrix_result_writer #(.N_ROWS(N_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_data  (in_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .checksum (checksum),
    .cycles   (cycles),
    .err      (err),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [ADDR_W-1:0] row;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              sb[$];
  logic [N_ROWS-1:0] seen;
  int                exp_count;
  logic [DATA_W-1:0] exp_sum;
  logic              exp_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    seen      = '0;
    exp_count = 0;
    exp_sum   = '0;
    exp_err   = 1'b0;
  endtask

  task automatic clear_phase();
    for (int i = 0; i < N_ROWS; i++) begin
      check("clear_in_ready_low", in_ready, 0);
      tick();
    end
    check("collect_in_ready_high", in_ready, 1);
  endtask

  task automatic start_and_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cycles_zero", cycles, 0);
    check("start_count_zero", count, 0);
    clear_phase();
  endtask

  // One beat on the stream; the model records what the buffer should now hold.
  task automatic send_beat(input logic [ADDR_W-1:0] row, input logic [DATA_W-1:0] data);
    in_valid = 1'b1;
    in_row   = row;
    in_data  = data;
    #1;
    check("beat_in_ready", in_ready, 1);
    if (!seen[row]) begin
      sb.push_back('{row: row, data: data});
      seen[row] = 1'b1;
      exp_count++;
      exp_sum = exp_sum + data;
    end else begin
      exp_err = 1'b1;
    end
    tick();
  endtask

  task automatic readback();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.row;
      tick();
      check("readback_data", rd_data, e.data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    KEY0 = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_row = '0; in_data = '0; rd_addr = '0;
    model_clear();

    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_cycles", cycles, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    KEY0 = 1'b0;
    tick(); tick();
    check("idle_in_ready", in_ready, 0);
    check("idle_cycles", cycles, 0);

    // 1: start, 128-cycle clear, readback of a cleared row
    rd_addr = 7'd17;
    start_and_clear();
    check("t1_rd17_zero", rd_data, 0);

    // 2: all rows in order, data = 3*row, back to back
    for (int r = 0; r < N_ROWS; r++) send_beat(ADDR_W'(r), DATA_W'(3 * r));
    in_valid = 1'b0;
    check("t2_done", done, 1);
    check("t2_count", count, 128);
    check("t2_checksum", checksum, 24384);
    check("t2_cycles", cycles, 256);
    check("t2_err", err, 0);
    readback();
    check("t2_cycles_frozen", cycles, 256);
    check("t2_done_holds", done, 1);

    // 3: duplicate row dropped and flagged
    model_clear();
    start_and_clear();
    send_beat(7'd5, 32'h11);
    send_beat(7'd5, 32'h22);
    in_valid = 1'b0;
    check("t3_count", count, exp_count);
    check("t3_count_one", count, 1);
    check("t3_checksum", checksum, 32'h11);
    check("t3_err", err, 1);
    check("t3_done", done, 0);
    readback();

    // 4: checksum wrap, random gaps, done only at the last row
    model_clear();
    start_and_clear();
    send_beat(7'd0, 32'hFFFF_FFFF);
    send_beat(7'd1, 32'h2);
    in_valid = 1'b0;
    check("t4_wrap", checksum, 32'h1);
    for (int r = 2; r < N_ROWS; r++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (gaps) tick();
      if (r == N_ROWS - 1) begin
        check("t4_not_done_early", done, 0);
        check("t4_count_127", count, 127);
      end
      send_beat(ADDR_W'(r), DATA_W'($urandom));
    end
    in_valid = 1'b0;
    check("t4_done", done, 1);
    check("t4_count", count, 128);
    check("t4_checksum", checksum, exp_sum);
    check("t4_err", err, 0);
    readback();

    // 5: start mid-collect wins over a valid beat
    model_clear();
    start_and_clear();
    for (int r = 0; r < 10; r++) send_beat(ADDR_W'(r), DATA_W'(100 + r));
    send_beat(7'd3, 32'h77);
    check("t5_err_before", err, 1);
    in_valid = 1'b1; in_row = 7'd10; in_data = 32'hDEAD;
    start = 1'b1;
    #1;
    check("t5_start_blocks_ready", in_ready, 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("t5_count", count, 0);
    check("t5_err", err, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_checksum", checksum, 0);
    check("t5_done", done, 0);
    check("t5_cycles", cycles, 0);
    rd_addr = 7'd17;
    clear_phase();
    check("t5_rd17_cleared", rd_data, 0);

    // 6: reset mid-collect
    model_clear();
    rd_addr = 7'd2;
    for (int r = 0; r < 4; r++) send_beat(ADDR_W'(r), DATA_W'(32'h55 + r));
    check("t6_rd_before_reset", rd_data, 32'h57);
    in_valid = 1'b1; in_row = 7'd4; in_data = 32'h99;
    #2;
    KEY0 = 1'b1;
    #1;
    check("t6_in_ready", in_ready, 0);
    check("t6_count", count, 0);
    check("t6_checksum", checksum, 0);
    check("t6_cycles", cycles, 0);
    check("t6_err", err, 0);
    check("t6_done", done, 0);
    check("t6_rd_data", rd_data, 0);
    tick(); tick();
    KEY0 = 1'b0;
    tick(); tick(); tick();
    check("t6_post_in_ready", in_ready, 0);
    check("t6_post_count", count, 0);
    check("t6_post_cycles", cycles, 0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
